// File: rtl/debounce_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding and counter widths.
package debounce_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned HOLD_W = 16;

    typedef enum logic [1:0] {
        StIdle           = 2'd0,
        StConfirmPress   = 2'd1,
        StPressed        = 2'd2,
        StConfirmRelease = 2'd3
    } deb_state_e;

endpackage

// File: rtl/edge_strobe.sv
// Registers a level and emits a one-cycle pulse on each rising edge of it.
// The history flop resets to 0, so a level that is 1 straight out of reset
// produces one strobe on the first cycle.
module edge_strobe (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic strobe
);

    logic level_q;

    // History flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign strobe = level & ~level_q;

endmodule

// File: rtl/key_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, sample strobes from the rising
// edges of clk_div, and a confirm-press/confirm-release FSM with registered
// level and press/release pulses.
// Optional long-press detection is compiled in with DEBOUNCE_LONG_PRESS_EN;
// without it long_pulse is tied to 0.
import debounce_pkg::*;

module key_debouncer #(
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned ACTIVE_LOW     = 1,
    parameter int unsigned LONG_SAMPLES   = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_div,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    // Raw pin level when the key is not pressed.
    localparam logic INACTIVE_RAW = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic       sync_1;
    logic       sync_2;
    logic       btn;
    logic       stb;
    deb_state_e state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer for the asynchronous key pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= INACTIVE_RAW;
            sync_2 <= INACTIVE_RAW;
        end else begin
            sync_1 <= btn_in;
            sync_2 <= sync_1;
        end
    end

    // Normalised so that btn = 1 means pressed.
    assign btn = (ACTIVE_LOW != 0) ? ~sync_2 : sync_2;

    // clk_div is sampled as data; its rising edges become the sample strobes.
    edge_strobe u_clk_div_strobe (
        .clk    (clk),
        .rst    (rst),
        .level  (clk_div),
        .strobe (stb)
    );

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_SAMPLES);
    logic [HOLD_W-1:0] hold_cnt;
`else
    logic unused_long_samples;
    assign unused_long_samples = (LONG_SAMPLES != 0);
    assign long_pulse = 1'b0;
`endif

    // Debounce FSM; advances only on strobes, outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef DEBOUNCE_LONG_PRESS_EN
            hold_cnt      <= '0;
            long_pulse    <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef DEBOUNCE_LONG_PRESS_EN
            long_pulse    <= 1'b0;
`endif
            if (stb) begin
                unique case (state)
                    StIdle: begin
                        if (btn) begin
                            state <= StConfirmPress;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    StConfirmPress: begin
                        if (!btn) begin
                            state <= StIdle;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state       <= StPressed;
                            cnt         <= '0;
                            press_pulse <= 1'b1;
                            btn_level   <= 1'b1;
`ifdef DEBOUNCE_LONG_PRESS_EN
                            hold_cnt    <= '0;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    StPressed: begin
`ifdef DEBOUNCE_LONG_PRESS_EN
                        // Saturating hold counter; fires once when it reaches the limit.
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_cnt + 1'b1;
                            if (hold_cnt == HOLD_LAST - 1'b1) begin
                                long_pulse <= 1'b1;
                            end
                        end
`endif
                        if (!btn) begin
                            state <= StConfirmRelease;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    StConfirmRelease: begin
                        // A bounce back to PRESSED keeps hold_cnt.
                        if (btn) begin
                            state <= StPressed;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state         <= StIdle;
                            cnt           <= '0;
                            release_pulse <= 1'b1;
                            btn_level     <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Randomised and directed bench for key_debouncer against a run-length
// reference model. Honours DEBOUNCE_LONG_PRESS_EN for the long-press checks.
module tb_key_debouncer;

    localparam int unsigned STABLE = 4;
    localparam int unsigned LONG   = 10;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic clk_div = 1'b0;
    logic btn_in  = 1'b1;
    logic btn_level, press_pulse, release_pulse, long_pulse;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned ph = 0;
    int unsigned n_press = 0, n_rel = 0, n_long = 0;

    // Reference model state (abstract: accepted level + run of disagreeing samples).
    logic        m_s1, m_s2, m_cd_q;
    logic        m_acc;
    int unsigned m_run, m_hold;
    logic        e_level, e_press, e_rel, e_long;

    key_debouncer #(
        .STABLE_SAMPLES (STABLE),
        .ACTIVE_LOW     (1),
        .LONG_SAMPLES   (LONG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_div       (clk_div),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_cd_q = 1'b0;
        m_acc = 1'b0; m_run = 0; m_hold = 0;
        e_level = 1'b0; e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge();
        logic stb, samp;
        stb  = clk_div & ~m_cd_q;
        samp = ~m_s2;
        m_s2 = m_s1; m_s1 = btn_in; m_cd_q = clk_div;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        if (stb) begin
`ifdef DEBOUNCE_LONG_PRESS_EN
            if (m_acc && m_run == 0 && m_hold < LONG) begin
                m_hold++;
                if (m_hold == LONG) e_long = 1'b1;
            end
`endif
            if (samp == m_acc) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == STABLE) begin
                    m_acc = samp;
                    m_run = 0;
                    if (samp) begin
                        e_press = 1'b1;
                        m_hold  = 0;
                    end else begin
                        e_rel = 1'b1;
                    end
                end
            end
        end
        e_level = m_acc;
    endtask

    task automatic cmp_all();
        check("btn_level", 32'(btn_level), 32'(e_level));
        check("press_pulse", 32'(press_pulse), 32'(e_press));
        check("release_pulse", 32'(release_pulse), 32'(e_rel));
        check("long_pulse", 32'(long_pulse), 32'(e_long));
    endtask

    task automatic step(input logic b, input logic r);
        @(negedge clk);
        btn_in  = b;
        rst     = r;
        clk_div = ((ph / 10) % 2) == 1;
        ph++;
        if (r) begin
            model_reset();
            #1;
            cmp_all();
        end
        @(posedge clk);
        if (!r) model_edge();
        #1;
        cmp_all();
        if (press_pulse) n_press++;
        if (release_pulse) n_rel++;
        if (long_pulse) n_long++;
    endtask

    task automatic hold(input logic b, input int unsigned cycles);
        for (int i = 0; i < cycles; i++) step(b, 1'b0);
    endtask

    task automatic clr_counts();
        n_press = 0; n_rel = 0; n_long = 0;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

        // Idle key: nothing happens.
        clr_counts();
        hold(1'b1, 200);
        check("idle_press_cnt", n_press, 0);
        check("idle_level", 32'(btn_level), 0);

        // Clean press, then clean release.
        clr_counts();
        hold(1'b0, 200);
        check("press_cnt", n_press, 1);
        check("press_level", 32'(btn_level), 1);
        clr_counts();
        hold(1'b1, 200);
        check("release_cnt", n_rel, 1);
        check("release_press_cnt", n_press, 0);

        // Bounce on press: exactly one press pulse.
        clr_counts();
        hold(1'b0, 40);
        hold(1'b1, 20);
        hold(1'b0, 200);
        check("bounce_press_cnt", n_press, 1);
        hold(1'b1, 200);

        // Long hold.
        clr_counts();
        hold(1'b0, 700);
        check("long_press_cnt", n_press, 1);
`ifdef DEBOUNCE_LONG_PRESS_EN
        check("long_cnt", n_long, 1);
`else
        check("long_cnt", n_long, 0);
`endif

        // Reset while pressed: level drops, no release, fresh press afterwards.
        clr_counts();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check("rst_level", 32'(btn_level), 0);
        check("rst_rel_cnt", n_rel, 0);
        hold(1'b0, 200);
        check("rst_repress_cnt", n_press, 1);
        check("rst_repress_rel_cnt", n_rel, 0);
        hold(1'b1, 200);

        // Random key activity.
        for (int s = 0; s < 50; s++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(5, 160));
        end
        hold(1'b1, 200);
        check("final_level", 32'(btn_level), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Debounces one mechanical push-button and produces a clean level plus one-cycle press/release pulses.
- Sits directly downstream of the clock divider: it takes the divider's slow square wave `clk_div` as its sample cadence.
- Runs entirely in the fast system clock domain; `clk_div` is used only as a data input, never as a clock.
- Outputs feed counters and FSMs elsewhere in the design.

Parameters:
- STABLE_SAMPLES, 4: consecutive identical samples required to accept a new key state; legal range 2..255.
- ACTIVE_LOW, 1: 1 means the raw key reads 0 when pressed; 0 means it reads 1 when pressed.
- LONG_SAMPLES, 50: samples the key must stay held before `long_pulse` fires; legal range 1..65535; used only with DEBOUNCE_LONG_PRESS_EN.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous, active-high reset.
- clk_div  input  1  slow square wave from the clock divider; each rising edge is one sample strobe.
- btn_in  input  1  raw asynchronous key pin.
- btn_level  output  1  debounced level; 1 means pressed.
- press_pulse  output  1  one `clk` cycle high when a press is accepted.
- release_pulse  output  1  one `clk` cycle high when a release is accepted.
- long_pulse  output  1  one `clk` cycle high on a long press; tied 0 when the feature is compiled out.

Behaviour:
- Reset (async, active-high): all state is cleared immediately.
  - FSM goes to IDLE; counters go to 0.
  - Synchronizer flops load the inactive key level.
  - `clk_div` history flop loads 0.
  - All outputs go to 0.
  - Reset asserted mid-press drops `btn_level` with no `release_pulse`.
- Synchronizer: `btn_in` passes through 2 flops, then is normalised so that `btn` = 1 means pressed (inverted when ACTIVE_LOW = 1).
- Strobe generation: `clk_div` is registered once; `stb = clk_div & ~clk_div_q`.
  - Exactly one `stb` per `clk_div` rising edge.
  - No strobes while the divider is held in reset (`clk_div` stays 0).
- The FSM and counter advance only on cycles where `stb` = 1. Changes of `btn` between strobes are ignored.
- Counter: 8-bit `cnt`.
- FSM states and transitions (each transition evaluated on a strobe):
  - IDLE: if `btn` = 1, go to CONFIRM_PRESS with `cnt` = 1.
  - CONFIRM_PRESS:
    - `btn` = 0: go to IDLE, `cnt` = 0.
    - `btn` = 1 and `cnt` = STABLE_SAMPLES-1: go to PRESSED, `cnt` = 0, `press_pulse` = 1.
    - otherwise: `cnt` increments.
  - PRESSED: if `btn` = 0, go to CONFIRM_RELEASE with `cnt` = 1.
  - CONFIRM_RELEASE:
    - `btn` = 1: go to PRESSED, `cnt` = 0.
    - `btn` = 0 and `cnt` = STABLE_SAMPLES-1: go to IDLE, `cnt` = 0, `release_pulse` = 1.
    - otherwise: `cnt` increments.
- Outputs are registered.
  - `btn_level` = 1 exactly while the state is PRESSED or CONFIRM_RELEASE; it rises in the same cycle as `press_pulse`.
  - Pulses assert in the `clk` cycle after the accepting strobe and last exactly one `clk` cycle.
  - `press_pulse` and `release_pulse` are never high together.
- Latency: a clean press is accepted on the STABLE_SAMPLES-th strobe seeing `btn` = 1; outputs change 1 `clk` later. Add 2 cycles of synchronizer delay before that.
- A glitch shorter than STABLE_SAMPLES strobes produces no pulse and no change of `btn_level`.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - A 16-bit `hold_cnt` clears on entry to PRESSED.
  - It increments on each strobe while in PRESSED and saturates at LONG_SAMPLES.
  - `long_pulse` fires once (one `clk` cycle) when `hold_cnt` reaches LONG_SAMPLES.
  - A bounce into CONFIRM_RELEASE that returns to PRESSED does not clear `hold_cnt`.
  - At most one `long_pulse` per accepted press.
- Undefined: `hold_cnt` is absent and `long_pulse` is constant 0.

Decomposition:
- Shared package `debounce_pkg` holds:
  - FSM state encoding: IDLE = 2'd0, CONFIRM_PRESS = 2'd1, PRESSED = 2'd2, CONFIRM_RELEASE = 2'd3.
  - CNT_W = 8 and HOLD_W = 16.
- One natural sub-module, `edge_strobe`: registers a level and emits a one-cycle rising-edge pulse. It is reused for `clk_div`.
- The synchronizer stays inline.

Test Plan:
- Reset, then `clk_div` toggling every 10 `clk` (period 20) with the key idle (`btn_in` = 1, ACTIVE_LOW) for 200 cycles → all outputs stay 0.
- `btn_in` drops to 0 and stays, STABLE_SAMPLES = 4 → `press_pulse` high for exactly 1 `clk`, one cycle after the 4th strobe seeing the press; `btn_level` = 1 from then on.
- Bounce: `btn_in` low for 2 strobes, high for 1, then low steadily → no pulse until 4 further consecutive low strobes; exactly one `press_pulse`.
- Release after an accepted press: `btn_in` = 1 for 4 strobes → one `release_pulse`; `btn_level` = 0 in the same cycle; `press_pulse` never coincides.
- Assert `rst` for 3 cycles while in PRESSED → `btn_level` = 0 immediately, no `release_pulse`; after reset with the key still held, a fresh `press_pulse` follows 4 strobes later.
- With DEBOUNCE_LONG_PRESS_EN and LONG_SAMPLES = 10, key held for 30 strobes → exactly one `long_pulse`, 10 strobes after `press_pulse`. Without the macro, `long_pulse` stays 0.
